// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter: round-robin arbiter sharing one byte stream toward usb_cdc.
// Each requester owns the stream for one burst, which ends on its last flag or
// after MAX_BURST bytes. A single registered output stage drives usb_cdc.
// Optional feature: define USB_IN_ARB_TIMEOUT_EN to release a stalled owner
// after TIMEOUT idle cycles.
module usb_in_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        last_g_q, last_g_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;

  logic [7:0]           sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 out_free;
  logic                 xfer;
  logic                 found;
  logic [IW-1:0]        pick;
  logic [IW-1:0]        cand;
  int                   idx_tmp;

`ifdef USB_IN_ARB_TIMEOUT_EN
  logic [15:0]          stall_q, stall_d;
`else
  // TIMEOUT only matters when the stall counter is built in.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // Select the granted requester's byte, valid and last flag (one-hot AND-OR).
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_data  = sel_data | req_data_i[8*k +: 8];
        sel_valid = sel_valid | req_valid_i[k];
        sel_last  = sel_last | req_last_i[k];
      end
    end
  end

  // Output register can take a byte when empty or draining this cycle.
  assign out_free    = !valid_q || in_ready_i;
  assign req_ready_o = (state_q == GRANT && out_free) ? grant_q : '0;
  assign xfer        = (state_q == GRANT) && out_free && sel_valid;

  // Round-robin search: first valid requester after the previous owner.
  always_comb begin
    found   = 1'b0;
    pick    = last_g_q;
    cand    = '0;
    idx_tmp = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_tmp = int'(last_g_q) + i;
      if (idx_tmp >= NUM_REQ) idx_tmp = idx_tmp - NUM_REQ;
      cand = IW'(idx_tmp);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state, grant, burst counter and output-stage logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_g_d = last_g_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
`ifdef USB_IN_ARB_TIMEOUT_EN
    stall_d  = stall_q;
`endif

    if (xfer) begin
      data_d  = sel_data;
      valid_d = 1'b1;
    end else if (in_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            grant_d[k] = (IW'(k) == pick);
          end
          last_g_d = pick;
          cnt_d    = '0;
          state_d  = GRANT;
`ifdef USB_IN_ARB_TIMEOUT_EN
          stall_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_d = cnt_q + 9'd1;
          if (sel_last || cnt_q == 9'(MAX_BURST - 1)) begin
            state_d = IDLE;
            grant_d = '0;
          end
`ifdef USB_IN_ARB_TIMEOUT_EN
          stall_d = '0;
        end else if (!sel_valid) begin
          // Owner has gone quiet: release after TIMEOUT idle cycles.
          if (stall_q == 16'(TIMEOUT - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            stall_d = '0;
          end else begin
            stall_d = stall_q + 16'd1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_g_q <= IW'(NUM_REQ - 1);
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifdef USB_IN_ARB_TIMEOUT_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_g_q <= last_g_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef USB_IN_ARB_TIMEOUT_EN
      stall_q  <= stall_d;
`endif
    end
  end

  assign in_data_o  = data_q;
  assign in_valid_o = valid_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q == GRANT) || valid_q;

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Directed testbench for usb_in_arbiter (NUM_REQ=2, MAX_BURST=8, TIMEOUT=10).
module tb_usb_in_arbiter;

  logic        clk;
  logic        rstn;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  usb_in_arbiter #(.NUM_REQ(2), .MAX_BURST(8), .TIMEOUT(10)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_data_i(req_data), .req_valid_i(req_valid), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .in_data_o(in_data), .in_valid_o(in_valid), .in_ready_i(in_ready),
    .grant_o(grant), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source model: per-requester byte lists consumed on valid&ready.
  logic [7:0] src_data [2][32];
  bit         src_last [2][32];
  int         src_len  [2];
  int         ptr      [2];
  bit         en       [2];
  bit         rdy_toggle;

  // Per-cycle trace sampled on the falling edge.
  logic [7:0] tr_data  [80];
  logic       tr_valid [80];
  logic       tr_ready [80];
  logic [1:0] tr_grant [80];
  logic [1:0] tr_rreq  [80];
  logic       tr_busy  [80];
  logic [7:0] rx_q [$];
  logic [1:0] gseq [$];
  logic [1:0] prev_grant;

  task automatic clear_src();
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; ptr[k] = 0; src_len[k] = 0;
      for (int i = 0; i < 32; i++) begin
        src_data[k][i] = 8'h00; src_last[k][i] = 1'b0;
      end
    end
    rx_q.delete();
    gseq.delete();
    prev_grant = 2'b00;
    rdy_toggle = 1'b0;
  endtask

  task automatic drive(input int c);
    for (int k = 0; k < 2; k++) begin
      if (en[k] && ptr[k] < src_len[k]) begin
        req_valid[k]       = 1'b1;
        req_data[8*k +: 8] = src_data[k][ptr[k]];
        req_last[k]        = src_last[k][ptr[k]];
      end else begin
        req_valid[k]       = 1'b0;
        req_data[8*k +: 8] = 8'h00;
        req_last[k]        = 1'b0;
      end
    end
    if (rdy_toggle) in_ready = (c % 4 == 0) || (c % 4 == 3);
    else            in_ready = 1'b1;
  endtask

  // Runs n cycles starting just after a rising edge; bounded by construction.
  task automatic run_cycles(input int n);
    bit acc [2];
    for (int c = 0; c < n; c++) begin
      drive(c);
      @(negedge clk);
      tr_data[c]  = in_data;
      tr_valid[c] = in_valid;
      tr_ready[c] = in_ready;
      tr_grant[c] = grant;
      tr_rreq[c]  = req_ready;
      tr_busy[c]  = busy;
      for (int k = 0; k < 2; k++) acc[k] = req_valid[k] && req_ready[k];
      if (in_valid && in_ready) begin
        rx_q.push_back(in_data);
        $display("cycle %0d: out byte %02h grant %b", c, in_data, grant);
      end
      if (grant != 2'b00 && grant != prev_grant) gseq.push_back(grant);
      prev_grant = grant;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) if (acc[k]) ptr[k] = ptr[k] + 1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_src();
    req_valid = 2'b00; req_last = 2'b00; req_data = 16'h0; in_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", in_valid); end
    checks++; if (in_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h want 00", in_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 7; i++) src_data[0][i] = 8'(i + 1);
    src_last[0][6] = 1'b1; src_len[0] = 7; en[0] = 1'b1;
    run_cycles(12);
    checks++; if (tr_grant[0] !== 2'b00) begin errors++; $display("FAIL single_grant_t0: got %b want 00", tr_grant[0]); end
    checks++; if (tr_grant[1] !== 2'b01) begin errors++; $display("FAIL single_grant_t1: got %b want 01", tr_grant[1]); end
    checks++; if (tr_rreq[1] !== 2'b01) begin errors++; $display("FAIL single_ready_t1: got %b want 01", tr_rreq[1]); end
    checks++; if (tr_valid[1] !== 1'b0) begin errors++; $display("FAIL single_valid_t1: got %b want 0", tr_valid[1]); end
    for (int c = 2; c <= 8; c++) begin
      checks++;
      if (tr_valid[c] !== 1'b1 || tr_data[c] !== 8'(c - 1)) begin
        errors++; $display("FAIL single_byte_c%0d: got v=%b %02h want v=1 %02h", c, tr_valid[c], tr_data[c], 8'(c - 1));
      end
    end
    checks++; if (tr_grant[8] !== 2'b00) begin errors++; $display("FAIL single_release: got %b want 00", tr_grant[8]); end
    checks++; if (tr_busy[8] !== 1'b1) begin errors++; $display("FAIL single_busy_drain: got %b want 1", tr_busy[8]); end
    checks++; if (tr_valid[9] !== 1'b0 || tr_busy[9] !== 1'b0) begin errors++; $display("FAIL single_idle_end: got v=%b busy=%b want 0 0", tr_valid[9], tr_busy[9]); end
    checks++; if (rx_q.size() != 7) begin errors++; $display("FAIL single_count: got %0d want 7", rx_q.size()); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_b [12];
    logic [1:0] exp_g [4];
    exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hA3, 8'hA4, 8'hA5, 8'hB3, 8'hB4, 8'hB5};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      src_data[0][i] = 8'hA0 + 8'(i);
      src_data[1][i] = 8'hB0 + 8'(i);
    end
    src_last[0][2] = 1'b1; src_last[0][5] = 1'b1;
    src_last[1][2] = 1'b1; src_last[1][5] = 1'b1;
    src_len[0] = 6; src_len[1] = 6; en[0] = 1'b1; en[1] = 1'b1;
    run_cycles(30);
    checks++; if (rx_q.size() != 12) begin errors++; $display("FAIL fair_count: got %0d want 12", rx_q.size()); end
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL fair_byte%0d: got %02h want %02h", i, rx_q[i], exp_b[i]); end
    end
    checks++; if (gseq.size() != 4) begin errors++; $display("FAIL fair_grants: got %0d want 4", gseq.size()); end
    for (int i = 0; i < 4 && i < gseq.size(); i++) begin
      checks++;
      if (gseq[i] !== exp_g[i]) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", i, gseq[i], exp_g[i]); end
    end
  endtask

  task automatic test_max_burst();
    int runs [4];
    int gaps [4];
    int nruns, ngaps, run_len, gap_len;
    do_reset();
    for (int i = 0; i < 20; i++) src_data[1][i] = 8'h40 + 8'(i);
    src_len[1] = 20; en[1] = 1'b1;
    run_cycles(40);
    nruns = 0; ngaps = 0; run_len = 0; gap_len = 0;
    for (int i = 0; i < 4; i++) begin runs[i] = 0; gaps[i] = 0; end
    for (int c = 0; c < 40; c++) begin
      if (tr_valid[c]) begin
        if (run_len == 0 && nruns > 0 && ngaps < 4) begin gaps[ngaps] = gap_len; ngaps++; end
        run_len++; gap_len = 0;
      end else begin
        if (run_len > 0) begin
          if (nruns < 4) runs[nruns] = run_len;
          nruns++;
        end
        run_len = 0; gap_len++;
      end
    end
    checks++; if (nruns != 3) begin errors++; $display("FAIL maxb_runs: got %0d want 3", nruns); end
    checks++; if (runs[0] != 8) begin errors++; $display("FAIL maxb_run0: got %0d want 8", runs[0]); end
    checks++; if (runs[1] != 8) begin errors++; $display("FAIL maxb_run1: got %0d want 8", runs[1]); end
    checks++; if (runs[2] != 4) begin errors++; $display("FAIL maxb_run2: got %0d want 4", runs[2]); end
    checks++; if (ngaps != 2 || gaps[0] != 1 || gaps[1] != 1) begin errors++; $display("FAIL maxb_gaps: got n=%0d %0d %0d want n=2 1 1", ngaps, gaps[0], gaps[1]); end
    checks++; if (rx_q.size() != 20) begin errors++; $display("FAIL maxb_count: got %0d want 20", rx_q.size()); end
    for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'h40 + 8'(i)) begin errors++; $display("FAIL maxb_byte%0d: got %02h want %02h", i, rx_q[i], 8'h40 + 8'(i)); end
    end
  endtask

  task automatic test_backpressure();
    int stalls, viol;
    do_reset();
    for (int i = 0; i < 16; i++) src_data[0][i] = 8'h80 + 8'(i);
    src_last[0][15] = 1'b1; src_len[0] = 16; en[0] = 1'b1;
    rdy_toggle = 1'b1;
    run_cycles(70);
    stalls = 0; viol = 0;
    for (int c = 1; c < 70; c++) begin
      if (tr_valid[c-1] && !tr_ready[c-1]) begin
        stalls++;
        if (tr_valid[c] !== 1'b1 || tr_data[c] !== tr_data[c-1]) viol++;
      end
    end
    checks++; if (stalls == 0) begin errors++; $display("FAIL bp_stalls: got 0 want >0"); end
    checks++; if (viol != 0) begin errors++; $display("FAIL bp_stable: got %0d violations want 0", viol); end
    checks++; if (rx_q.size() != 16) begin errors++; $display("FAIL bp_count: got %0d want 16", rx_q.size()); end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'h80 + 8'(i)) begin errors++; $display("FAIL bp_byte%0d: got %02h want %02h", i, rx_q[i], 8'h80 + 8'(i)); end
    end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL bp_release: got %b want 00", grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) src_data[0][i] = 8'h20 + 8'(i);
    src_len[0] = 10; en[0] = 1'b1;
    run_cycles(5);
    checks++; if (in_data !== 8'h23 || in_valid !== 1'b1) begin errors++; $display("FAIL rmid_byte4: got v=%b %02h want v=1 23", in_valid, in_data); end
    rstn = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant: got %b want 00", grant); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rmid_ready: got %b want 00", req_ready); end
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", in_valid); end
    checks++; if (in_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %02h want 00", in_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    ptr[0] = 0; ptr[1] = 0;
    for (int i = 0; i < 4; i++) src_data[1][i] = 8'h30 + 8'(i);
    src_len[1] = 4; en[1] = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    prev_grant = 2'b00;
    run_cycles(3);
    checks++; if (tr_grant[1] !== 2'b01) begin errors++; $display("FAIL rmid_first_winner: got %b want 01", tr_grant[1]); end
  endtask

  task automatic test_timeout();
    int g1_cycles;
    do_reset();
    src_data[0][0] = 8'h51; src_data[0][1] = 8'h52; src_len[0] = 2; en[0] = 1'b1;
    for (int i = 0; i < 4; i++) src_data[1][i] = 8'h61 + 8'(i);
    src_last[1][3] = 1'b1; src_len[1] = 4; en[1] = 1'b1;
    run_cycles(30);
    g1_cycles = 0;
    for (int c = 0; c < 30; c++) if (tr_grant[c] == 2'b10) g1_cycles++;
`ifdef USB_IN_ARB_TIMEOUT_EN
    checks++; if (tr_grant[12] !== 2'b01) begin errors++; $display("FAIL to_hold: got %b want 01", tr_grant[12]); end
    checks++; if (tr_grant[13] !== 2'b00) begin errors++; $display("FAIL to_release: got %b want 00", tr_grant[13]); end
    checks++; if (tr_grant[14] !== 2'b10) begin errors++; $display("FAIL to_regrant: got %b want 10", tr_grant[14]); end
    checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL to_count: got %0d want 6", rx_q.size()); end
`else
    checks++; if (g1_cycles != 0) begin errors++; $display("FAIL nto_never: got %0d cycles granted to 1 want 0", g1_cycles); end
    checks++; if (tr_grant[29] !== 2'b01) begin errors++; $display("FAIL nto_hold: got %b want 01", tr_grant[29]); end
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL nto_count: got %0d want 2", rx_q.size()); end
`endif
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 2'b00; req_last = 2'b00; req_data = 16'h0; in_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_max_burst();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
